// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the program ROM address from an internal pc and
// queues {pc, instr} pairs in a small FIFO for decode, with redirect flush and halt.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] addr_bus,
    input  logic [31:0] data_bus,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      buf_pc_q    [DEPTH];
    logic [31:0]      buf_instr_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign addr_bus  = {2'b00, pc_q[31:2]};
    assign out_valid = (count_q != '0);
    assign out_instr = buf_instr_q[rd_ptr_q];
    assign out_pc    = buf_pc_q[rd_ptr_q];

    // Redirect wins over everything: the head is not consumed in a flush cycle.
    assign pop  = out_valid & out_ready & ~redirect_valid;
    assign push = ~redirect_valid & ~halt & ((count_q < FULL) | pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= PC_INIT;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so out_instr/out_pc read zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else if (push) begin
            buf_pc_q[wr_ptr_q]    <= pc_q;
            buf_instr_q[wr_ptr_q] <= data_bus;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM model on addr_bus/data_bus, hand-computed
// expectations for streaming, back-pressure, redirect, wrap, halt and async reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] addr_bus;
    logic [31:0] data_bus;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Words 0..4 hold 0x11..0x55; every other word returns a tag of its address.
    function automatic logic [31:0] rom(input logic [31:0] w);
        case (w)
            32'd0:   return 32'h0000_0011;
            32'd1:   return 32'h0000_0022;
            32'd2:   return 32'h0000_0033;
            32'd3:   return 32'h0000_0044;
            32'd4:   return 32'h0000_0055;
            default: return {8'hA5, w[23:0]};
        endcase
    endfunction

    assign data_bus = rom(addr_bus);

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr_bus       (addr_bus),
        .data_bus       (data_bus),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_instr [4];

    initial begin
        exp_instr[0] = 32'h11;
        exp_instr[1] = 32'h22;
        exp_instr[2] = 32'h33;
        exp_instr[3] = 32'h44;

        rst_n          = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_pc", out_pc, 32'd0);
        check_eq("rst_addr", addr_bus, 32'd0);

        // Streaming with decode always ready
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("first_addr", addr_bus, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check_eq("stream_valid", 32'(out_valid), 32'd1);
            check_eq("stream_pc", out_pc, 32'(4 * k));
            check_eq("stream_instr", out_instr, exp_instr[k]);
            check_eq("stream_addr", addr_bus, 32'(k + 1));
        end

        // Back-pressure: buffer fills, pc stops, head holds
        rst_n     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc();
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        check_eq("bp_pc", out_pc, 32'd0);
        check_eq("bp_instr", out_instr, 32'h11);
        check_eq("bp_addr", addr_bus, 32'd2);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cyc();
            check_eq("drain_valid", 32'(out_valid), 32'd1);
            check_eq("drain_pc", out_pc, 32'(4 * k));
            check_eq("drain_instr", out_instr, exp_instr[k]);
        end

        // Redirect with full buffer, decode stalled; low address bits ignored
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0013;
        cyc();
        check_eq("redir_valid", 32'(out_valid), 32'd0);
        check_eq("redir_addr", addr_bus, 32'd4);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        cyc();
        check_eq("redir_tvalid", 32'(out_valid), 32'd1);
        check_eq("redir_tpc", out_pc, 32'h10);
        check_eq("redir_tinstr", out_instr, 32'h55);

        // Redirect together with out_ready on a full buffer: head must not leave
        out_ready = 1'b0;
        cyc();
        check_eq("hold_pc", out_pc, 32'h10);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0008;
        cyc();
        check_eq("rpop_valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        cyc();
        check_eq("rpop_pc", out_pc, 32'h8);
        check_eq("rpop_instr", out_instr, 32'h33);

        // pc wrap through the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        check_eq("wrap_addr", addr_bus, 32'h3FFF_FFFF);
        redirect_valid = 1'b0;
        cyc();
        check_eq("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        check_eq("wrap_instr0", out_instr, 32'hA5FF_FFFF);
        cyc();
        check_eq("wrap_pc1", out_pc, 32'h0);
        check_eq("wrap_instr1", out_instr, 32'h11);
        cyc();
        check_eq("wrap_pc2", out_pc, 32'h4);

        // Halt: buffer drains, pc frozen, fetch resumes when halt drops
        halt = 1'b1;
        cyc();
        check_eq("halt_valid0", 32'(out_valid), 32'd0);
        check_eq("halt_addr0", addr_bus, 32'd2);
        cyc();
        check_eq("halt_valid1", 32'(out_valid), 32'd0);
        check_eq("halt_addr1", addr_bus, 32'd2);
        halt = 1'b0;
        cyc();
        check_eq("resume_valid", 32'(out_valid), 32'd1);
        check_eq("resume_pc", out_pc, 32'h8);
        check_eq("resume_instr", out_instr, 32'h33);

        // Asynchronous reset mid-stream with a full buffer
        out_ready = 1'b0;
        cyc();
        check_eq("full_pc", out_pc, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_pc", out_pc, 32'd0);
        check_eq("arst_instr", out_instr, 32'd0);
        check_eq("arst_addr", addr_bus, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cyc();
        check_eq("restart_valid", 32'(out_valid), 32'd1);
        check_eq("restart_pc", out_pc, 32'd0);
        check_eq("restart_instr", out_instr, 32'h11);
        cyc();
        check_eq("restart_pc1", out_pc, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
